// File: rtl/ring_freq_meter.sv
// Sequencer and gated edge counter for a tapped inverter ring: settles the ring,
// counts synchronised rising edges over 2^GATE_BITS clocks, and hands results out via valid/ready.
module ring_freq_meter #(
  parameter int GATE_BITS     = 16,
  parameter int COUNT_W       = 20,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int LAST_TAP      = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sweep,
  input  logic [3:0]         tap_sel,
  input  logic               osc_in,
  output logic               ring_ena,
  output logic [3:0]         ring_tap,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [COUNT_W-1:0] result_count,
  output logic [3:0]         result_tap,
  output logic               result_ovf,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, GATE = 2'd2, HOLD = 2'd3} state_t;

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int TIMER_W  = (GATE_BITS > SETTLE_W) ? GATE_BITS : SETTLE_W;
  localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'({GATE_BITS{1'b1}});
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [3:0]         TAP_LAST    = 4'(LAST_TAP);

  // Handshake: a result transfers on any cycle where result_valid && result_ready;
  // result_valid never drops and the result fields never change until that transfer.

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [COUNT_W-1:0]   count, count_next;
  logic                 ovf_int, ovf_next;
  logic                 sweep_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_prev;
  logic                 osc_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], osc_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // Saturating increment; the flag records that the counter reached all-ones.
  always_comb begin
    count_next = count;
    if (osc_rise && (count != COUNT_MAX)) count_next = count + COUNT_W'(1);
    ovf_next = ovf_int | (count_next == COUNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      count        <= '0;
      ovf_int      <= 1'b0;
      sweep_q      <= 1'b0;
      ring_ena     <= 1'b0;
      ring_tap     <= 4'd0;
      result_valid <= 1'b0;
      result_count <= '0;
      result_tap   <= 4'd0;
      result_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sweep_q  <= sweep;
            ring_tap <= sweep ? 4'd0 : tap_sel;
            ring_ena <= 1'b1;
            timer    <= '0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer   <= '0;
            count   <= '0;
            ovf_int <= 1'b0;
            state   <= GATE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        GATE: begin
          count   <= count_next;
          ovf_int <= ovf_next;
          if (timer == GATE_LAST) begin
            result_count <= count_next;
            result_ovf   <= ovf_next;
            result_tap   <= ring_tap;
            result_valid <= 1'b1;
            ring_ena     <= 1'b0;
            state        <= HOLD;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (sweep_q && (ring_tap < TAP_LAST)) begin
              ring_tap <= ring_tap + 4'd1;
              ring_ena <= 1'b1;
              timer    <= '0;
              state    <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter: single tap, reset abort, overflow with backpressure,
// ignored start and a full sweep, all against hand-computed expectations.
module tb_ring_freq_meter;

  localparam int GATE_BITS = 8;
  localparam int COUNT_W   = 6;
  localparam int SETTLE    = 16;
  localparam int LAST_TAP  = 13;

  logic               clk = 1'b0;
  logic               rst_n, start, sweep, osc_in, result_ready;
  logic [3:0]         tap_sel;
  logic               ring_ena, busy, result_valid, result_ovf;
  logic [3:0]         ring_tap, result_tap;
  logic [COUNT_W-1:0] result_count;
  logic [1:0]         state_dbg;

  int tests = 0;
  int failed = 0;
  int osc_half = 0;
  int osc_cnt = 0;
  logic [31:0] exp_q[$];

  ring_freq_meter #(
    .GATE_BITS(GATE_BITS), .COUNT_W(COUNT_W), .SETTLE_CYCLES(SETTLE),
    .SYNC_STAGES(2), .LAST_TAP(LAST_TAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep(sweep), .tap_sel(tap_sel),
    .osc_in(osc_in), .ring_ena(ring_ena), .ring_tap(ring_tap), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count), .result_tap(result_tap), .result_ovf(result_ovf),
    .state_dbg(state_dbg)
  );

  // clock / oscillator stimulus
  always #5 clk = ~clk;

  initial osc_in = 1'b0;
  always @(negedge clk) begin
    if (osc_half == 0) begin
      osc_in = 1'b0;
      osc_cnt = 0;
    end else if (osc_cnt >= osc_half - 1) begin
      osc_in = ~osc_in;
      osc_cnt = 0;
    end else begin
      osc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic sw, input logic [3:0] tap);
    sweep = sw;
    tap_sel = tap;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, ok, 1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ena"}, ring_ena, 0);
    check({tag, "_tap"}, ring_tap, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_count"}, result_count, 0);
    check({tag, "_rtap"}, result_tap, 0);
    check({tag, "_ovf"}, result_ovf, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    logic tap_ok, early, stable_ok, no_valid;
    logic [COUNT_W-1:0] cap_count;
    logic [3:0] cap_tap;
    int ena_low, extra;

    rst_n = 1'b0; start = 1'b0; sweep = 1'b0; tap_sel = 4'd0; result_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // single tap 5, edge every 8 clk over 256-cycle gate -> 32 +/- 1
    osc_half = 4;
    kick(1'b0, 4'd5);
    check("c1_busy", busy, 1);
    check("c1_ena", ring_ena, 1);
    check("c1_tap", ring_tap, 5);
    tap_ok = 1'b1; early = 1'b0;
    for (int i = 2; i <= SETTLE + 256; i++) begin
      tick();
      if (ring_tap !== 4'd5) tap_ok = 1'b0;
      if (result_valid) early = 1'b1;
    end
    check("single_early_valid", early, 0);
    check("single_ena_gate_end", ring_ena, 1);
    tick();
    check("single_valid_273", result_valid, 1);
    check("single_ena_hold", ring_ena, 0);
    check("single_tap_stable", tap_ok, 1);
    check("single_count_32pm1", (result_count >= 31 && result_count <= 33), 1);
    check("single_rtap", result_tap, 5);
    check("single_ovf", result_ovf, 0);
    accept();
    check("single_valid_clr", result_valid, 0);
    check("single_idle", busy, 0);

    // reset in the middle of the gate window
    kick(1'b0, 4'd3);
    repeat (SETTLE + 100) tick();
    check("midgate_state", state_dbg, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_vals("midrst");
    no_valid = 1'b1;
    repeat (400) begin
      tick();
      if (result_valid || busy) no_valid = 1'b0;
    end
    check("midrst_quiet", no_valid, 1);
    kick(1'b0, 4'd7);
    wait_valid("wait_after_rst");
    check("after_rst_count", (result_count >= 31 && result_count <= 33), 1);
    check("after_rst_tap", result_tap, 7);
    accept();

    // overflow: edge every 2 clk -> 128 edges saturates 6-bit counter at 63
    osc_half = 1;
    kick(1'b0, 4'd4);
    wait_valid("wait_ovf");
    check("ovf_count", result_count, 63);
    check("ovf_flag", result_ovf, 1);
    cap_count = result_count; cap_tap = result_tap;
    stable_ok = 1'b1;
    repeat (100) begin
      tick();
      if (!result_valid || ring_ena || result_count !== cap_count ||
          result_tap !== cap_tap || !result_ovf || state_dbg !== 2'd3) stable_ok = 1'b0;
    end
    check("backpressure_stable", stable_ok, 1);
    accept();
    check("bp_accept_valid", result_valid, 0);
    check("bp_accept_idle", busy, 0);
    no_valid = 1'b1;
    repeat (5) begin
      tick();
      if (result_valid || busy) no_valid = 1'b0;
    end
    check("bp_single_accept", no_valid, 1);

    osc_half = 4;
    kick(1'b0, 4'd6);
    wait_valid("wait_slow");
    check("slow_ovf_clear", result_ovf, 0);
    check("slow_count", (result_count >= 31 && result_count <= 33), 1);
    accept();

    // start pulse during GATE of a tap-2 measurement must be ignored
    kick(1'b0, 4'd2);
    repeat (SETTLE + 50) tick();
    kick(1'b1, 4'd9);
    sweep = 1'b0;
    wait_valid("wait_ign");
    check("ign_rtap", result_tap, 2);
    check("ign_ring_tap", ring_tap, 2);
    accept();
    check("ign_idle", busy, 0);
    no_valid = 1'b1;
    repeat (300) begin
      tick();
      if (result_valid || busy) no_valid = 1'b0;
    end
    check("ign_no_second", no_valid, 1);

    // sweep with ready held high
    for (int t = 0; t <= LAST_TAP; t++) exp_q.push_back(t);
    result_ready = 1'b1;
    kick(1'b1, 4'd11);
    sweep = 1'b0;
    ena_low = 0; extra = 0;
    for (int i = 0; i < 6000; i++) begin
      if (!busy) break;
      if (result_valid) begin
        if (exp_q.size() == 0) extra++;
        else check("sweep_tap", result_tap, exp_q.pop_front());
      end
      if (!ring_ena) ena_low++;
      tick();
    end
    result_ready = 1'b0;
    check("sweep_all_seen", exp_q.size(), 0);
    check("sweep_extra", extra, 0);
    check("sweep_ena_low", ena_low, LAST_TAP + 1);
    check("sweep_done_idle", busy, 0);
    check("sweep_last_tap", ring_tap, LAST_TAP);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
